// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: idle-mode opcodes and
// burst controller state.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst sequencer: loads on start, counts WIDTH enabled shifts, then emits a
// one-cycle done. Tells the datapath when to load, burst-shift or run a mode.
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic start,
  output logic busy,
  output logic done,
  output logic shift_en,
  output logic load_en,
  output logic mode_en
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift_en  = 1'b0;
    load_en   = 1'b0;
    mode_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) begin
          if (start) begin
            load_en   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = ST_SHIFT;
          end else begin
            mode_en = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (en) begin
          shift_en = 1'b1;
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            state_nxt = ST_DONE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      // DONE lasts one cycle whatever en does; start is not looked at here.
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // busy/done come straight from flops so they are glitch-free and exclusive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt == ST_SHIFT);
      done  <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: rtl/universal_shift_reg_n.sv
// Parametrised universal shift register with rotate/arithmetic modes, clock
// enable and a self-timed WIDTH-bit burst serialiser.
module universal_shift_reg_n
  import usr_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit BURST_DIR = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             serial_left_in,
  input  logic             serial_right_in,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             start,
  output logic [WIDTH-1:0] parallel_data_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] q, q_nxt;
  logic             shift_en, load_en, mode_en;

  usr_burst_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .shift_en (shift_en),
    .load_en  (load_en),
    .mode_en  (mode_en)
  );

  always_comb begin
    q_nxt = q;
    if (load_en) begin
      q_nxt = parallel_in;
    end else if (shift_en) begin
      q_nxt = BURST_DIR ? {serial_left_in, q[WIDTH-1:1]}
                        : {q[WIDTH-2:0], serial_right_in};
    end else if (mode_en) begin
      case (mode)
        MODE_HOLD: q_nxt = q;
        MODE_SHR:  q_nxt = {serial_left_in, q[WIDTH-1:1]};
        MODE_SHL:  q_nxt = {q[WIDTH-2:0], serial_right_in};
        MODE_LOAD: q_nxt = parallel_in;
        MODE_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
        MODE_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
        MODE_ASR:  q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
        MODE_CLR:  q_nxt = '0;
        default:   q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= q_nxt;
  end

  assign parallel_data_out = q;
  // The bit leaving the register first is always visible, even outside a burst.
  assign serial_out        = BURST_DIR ? q[0] : q[WIDTH-1];

endmodule
